ad2_scan_sched: RTL and testbench
=================================

// Module: ad2_scan_sched
// PURPOSE
//  Scan scheduler for the AD2 (ad2adc) converter driver: cycles through enabled
//  channels 0..3, configures the ADC per channel via the adccf/cfadc handshake,
//  acquires samples via adcdav/davadc, averages 2^AVG_LOG2 samples per channel
//  and holds one result per channel for display/readout logic (BCD/LCD path).
//  Replaces a fixed single-channel sequencer. Runs on the ADC clock domain.
// PARAMETERS
//  AVG_LOG2  0     log2 samples averaged per stored result (0..4)
//  TIMEOUT   4095  max cycles waiting on any cfadc/davadc edge before abort
//  CONF_LO   4'h0  adcconf[3:0] (ref select, filter, delay bits), fixed
// PORTS
//  CLK      in   1   ADC clock (200 kHz); all logic posedge
//  RESET    in   1   asynchronous, active-high; clears all state
//  run      in   1   level: 1 = scan continuously, 0 = stop after current channel
//  chmask   in   4   channel enable, bit k = channel k
//  adccf    out  1   configure request to ad2adc
//  cfadc    in   1   configure acknowledge from ad2adc
//  adcconf  out  8   config byte: [7:4] one-hot channel (bit 4+k = ch k), [3:0] CONF_LO
//  adcdav   out  1   acquire request to ad2adc
//  davadc   in   1   acquire acknowledge / data valid
//  adcdata  in   12  conversion result
//  adcch    in   2   channel id reported with adcdata
//  rdsel    in   2   readout channel select
//  rddata   out  12  stored result of channel rdsel (registered)
//  valid    out  4   bit k = channel k holds at least one result
//  busy     out  1   1 in any state other than IDLE
//  scan_done out 1   1-cycle pulse after last enabled channel of a pass is stored
//  err      out  1   sticky error flag
//  errcode  out  2   01 timeout, 10 channel mismatch (last error wins)
//  errclr   in   1   clears err/errcode; a new error in the same cycle wins
// BEHAVIOUR
//  Reset: all outputs 0, adcconf=8'h00, results 0, state IDLE, ch=0, accumulators 0.
//  States: IDLE, CONF, CFREL, ACQ, DVREL, STORE, NEXT.
//  IDLE: leave when run=1 & chmask!=0 & cfadc=0 & davadc=0; ch = lowest enabled -> CONF.
//  CONF: adcconf={onehot(ch),CONF_LO}, adccf=1; on cfadc=1: adccf=0 -> CFREL.
//  CFREL: wait cfadc=0 -> ACQ (full 4-phase; never re-request while ack high).
//  ACQ: adcdav=1; on davadc=1: adcdav=0, capture adcdata/adcch -> DVREL.
//  DVREL: wait davadc=0 -> STORE.
//  STORE (1 cycle): if adcch!=ch: discard, clear acc, err=1, errcode=10 -> NEXT.
//   else acc+=adcdata (width 12+AVG_LOG2), n+=1; if n<2^AVG_LOG2 -> ACQ
//   (no reconfigure); else result[ch]=acc>>AVG_LOG2 (truncate), valid[ch]=1,
//   acc=0, n=0 -> NEXT.
//  NEXT: sample chmask; ch = next enabled index above ch, wrapping 3->0.
//   If wrapping (or sole channel), pulse scan_done.
//   run=0 or chmask=0 -> IDLE; else -> CONF (reconfigure every channel change;
//   also when only one channel enabled).
//  Timeout: counter clears on state entry; after TIMEOUT cycles in CONF/CFREL/ACQ/
//   DVREL: drop adccf/adcdav, err=1, errcode=01, clear acc/n, -> IDLE.
//  run=0 mid-channel: current handshakes and averaging block complete first.
//  chmask change mid-channel: ignored until NEXT. Stored results/valid retained
//   when a channel is disabled.
//  Readout: rddata <= result[rdsel] every cycle (1-cycle latency); a STORE to
//   channel rdsel appears on rddata one cycle after the result register updates.
//  RESET asserted mid-handshake: adccf/adcdav drop immediately (async).
//  Requests are registered outputs; never asserted together.
// TESTING
//  1 chmask=0101, run=1, AVG_LOG2=0, model returns ch0=1234, ch2=4095 ->
//    adcconf 8'h10 then 8'h40; rddata(rdsel=0)=1234, (rdsel=2)=4095; valid=0101;
//    scan_done each wrap.
//  2 AVG_LOG2=2, ch1 samples 100,101,102,103 -> one CONF (8'h20), four ACQ
//    handshakes, result[1]=101.
//  3 Model never raises davadc -> after 4095 cycles in ACQ: adcdav=0, err=1,
//    errcode=01, IDLE; errclr -> err=0; scan restarts since run=1.
//  4 Model reports adcch=3 while ch=1 -> result[1] unchanged, err=1,
//    errcode=10, scheduler advances to next enabled channel.
//  5 run dropped during ACQ of ch2 -> handshake completes, result[2] stored,
//    busy=0 in IDLE; model holds cfadc high -> IDLE waits, no new adccf.
//  6 RESET pulsed while adccf=1 -> adccf=0 same cycle, valid=0000, rddata=0.

Source files
------------

// File: rtl/ad2_scan_sched_if.sv
// ad2_scan_sched_if: configure/acquire handshake and sample bus between the scan scheduler and ad2adc
interface ad2_scan_sched_if;
    logic        adccf;
    logic        cfadc;
    logic [7:0]  adcconf;
    logic        adcdav;
    logic        davadc;
    logic [11:0] adcdata;
    logic [1:0]  adcch;
    modport master (output adccf, adcconf, adcdav, input cfadc, davadc, adcdata, adcch);
    modport slave  (input adccf, adcconf, adcdav, output cfadc, davadc, adcdata, adcch);
endinterface

// File: rtl/ad2_scan_sched.sv
// ad2_scan_sched: scans enabled ADC channels, averages 2^AVG_LOG2 samples each, holds one result per channel
module ad2_scan_sched #(
    parameter int         AVG_LOG2 = 0,
    parameter int         TIMEOUT  = 4095,
    parameter logic [3:0] CONF_LO  = 4'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    ad2_scan_sched_if.master        adc,
    input  logic                    run,
    input  logic [3:0]              chmask,
    input  logic [1:0]              rdsel,
    output logic [11:0]             rddata,
    output logic [3:0]              valid,
    output logic                    busy,
    output logic                    scan_done,
    output logic                    err,
    output logic [1:0]              errcode,
    input  logic                    errclr
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [NW-1:0] NLAST = NW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CONF, CFREL, ACQ, DVREL, STORE, NEXT} state_t;

    state_t        state, state_d;
    logic [1:0]    ch, ch_d, first, nxt;
    logic [TW-1:0] tcnt;
    logic [AW-1:0] acc, acc_sum;
    logic [NW-1:0] n;
    logic [11:0]   cap_data;
    logic [1:0]    cap_ch;
    logic [11:0]   result [4];
    logic          tmo, wrap, mism, last, abort;

    assign busy = state != IDLE;

    always_comb begin
        first = 2'd0;
        nxt = ch;
        for (int i = 3; i >= 0; i--) if (chmask[2'(i)]) first = 2'(i);
        // smallest forward offset wins; falls back to ch itself when it is the only one enabled
        for (int i = 3; i >= 1; i--) if (chmask[ch + 2'(i)]) nxt = ch + 2'(i);
        wrap = nxt <= ch;
        tmo = tcnt == TLAST;
        mism = cap_ch != ch;
        last = n == NLAST;
        acc_sum = acc + AW'(cap_data);
        state_d = state;
        ch_d = ch;
        case (state)
            IDLE: if (run && |chmask && !adc.cfadc && !adc.davadc) begin
                state_d = CONF;
                ch_d = first;
            end
            CONF:  state_d = adc.cfadc ? CFREL : tmo ? IDLE : CONF;
            CFREL: state_d = !adc.cfadc ? ACQ : tmo ? IDLE : CFREL;
            ACQ:   state_d = adc.davadc ? DVREL : tmo ? IDLE : ACQ;
            DVREL: state_d = !adc.davadc ? STORE : tmo ? IDLE : DVREL;
            STORE: state_d = (mism || last) ? NEXT : ACQ;
            NEXT: begin
                ch_d = nxt;
                state_d = (run && |chmask) ? CONF : IDLE;
            end
            default: state_d = IDLE;
        endcase
        abort = (state inside {CONF, CFREL, ACQ, DVREL}) && state_d == IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch <= '0;
            tcnt <= '0;
            acc <= '0;
            n <= '0;
            cap_data <= '0;
            cap_ch <= '0;
            for (int i = 0; i < 4; i++) result[i] <= '0;
            valid <= '0;
            rddata <= '0;
            scan_done <= 1'b0;
            err <= 1'b0;
            errcode <= 2'b00;
            adc.adccf <= 1'b0;
            adc.adcdav <= 1'b0;
            adc.adcconf <= 8'h00;
        end else begin
            ch <= ch_d;
            tcnt <= (state_d != state) ? '0 : tcnt + TW'(1);
            adc.adccf <= state_d == CONF;
            adc.adcdav <= state_d == ACQ;
            if (state_d == CONF) adc.adcconf <= {4'(1 << ch_d), CONF_LO};
            if (state == ACQ && adc.davadc) begin
                cap_data <= adc.adcdata;
                cap_ch <= adc.adcch;
            end
            scan_done <= state == NEXT && wrap && |chmask;
            if (state == STORE) begin
                acc <= (mism || last) ? '0 : acc_sum;
                n <= (mism || last) ? '0 : n + NW'(1);
                if (!mism && last) begin
                    result[ch] <= acc_sum[AVG_LOG2 +: 12];
                    valid[ch] <= 1'b1;
                end
            end
            if (abort) begin
                acc <= '0;
                n <= '0;
            end
            rddata <= result[rdsel];
            if (abort) {err, errcode} <= 3'b101;
            else if (state == STORE && mism) {err, errcode} <= 3'b110;
            else if (errclr) {err, errcode} <= 3'b000;
        end
    end
endmodule

// File: tb/tb_ad2_scan_sched.sv
// tb_ad2_scan_sched: randomized ADC responder with a transaction-level model of per-channel averaging
module tb_ad2_scan_sched;
    logic        clk = 0, rst, run, errclr;
    logic [3:0]  chmask, valid;
    logic [1:0]  rdsel, errcode;
    logic [11:0] rddata;
    logic        busy, scan_done, err;

    ad2_scan_sched_if bus();

    ad2_scan_sched #(.AVG_LOG2(2)) dut (
        .clk(clk), .rst(rst), .adc(bus), .run(run), .chmask(chmask), .rdsel(rdsel),
        .rddata(rddata), .valid(valid), .busy(busy), .scan_done(scan_done),
        .err(err), .errcode(errcode), .errclr(errclr)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    int sd_cnt = 0, overlap = 0, cf_cyc = 0, dav_run = 0, dav_max = 0, acq_n = 0;
    logic        hold_cf, mute, bad_on, rnd_data;
    logic [11:0] chval [4];
    logic [7:0]  conf_q [$];
    logic [11:0] data_q [$];
    logic [1:0]  cfg_ch = 0;
    int          msum = 0, mcnt = 0;
    logic [11:0] exp_res [4];
    logic [3:0]  exp_valid = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ohidx(logic [7:0] c);
        ohidx = 0;
        for (int k = 0; k < 4; k++) if (c[4+k]) ohidx = 2'(k);
    endfunction

    always @(negedge clk) begin
        if (scan_done) sd_cnt <= sd_cnt + 1;
        if (bus.adccf && bus.adcdav) overlap <= overlap + 1;
        if (bus.adccf) cf_cyc <= cf_cyc + 1;
        dav_run <= bus.adcdav ? dav_run + 1 : 0;
        if (dav_run > dav_max) dav_max <= dav_run;
    end

    // ADC responder: random ack latency, feeds every delivered sample into the averaging model
    initial begin
        int dly;
        logic [11:0] v;
        logic [1:0] rc;
        bus.cfadc = 0; bus.davadc = 0; bus.adcdata = 0; bus.adcch = 0; dly = 0;
        forever begin
            @(posedge clk); #1;
            if (hold_cf) bus.cfadc = 1;
            else if (bus.cfadc != bus.adccf) begin
                if (dly > 0) dly--;
                else begin
                    dly = $urandom_range(0, 3);
                    bus.cfadc = bus.adccf;
                    if (bus.adccf) begin
                        conf_q.push_back(bus.adcconf);
                        cfg_ch = ohidx(bus.adcconf);
                        msum = 0; mcnt = 0;
                    end
                end
            end
            if (bus.davadc != bus.adcdav && !(mute && bus.adcdav)) begin
                if (dly > 0) dly--;
                else begin
                    dly = $urandom_range(0, 3);
                    if (bus.adcdav) begin
                        v = data_q.size() > 0 ? data_q.pop_front() :
                            rnd_data ? 12'($urandom_range(0, 4095)) : chval[cfg_ch];
                        rc = (bad_on && cfg_ch == 2'd1) ? 2'd3 : cfg_ch;
                        bus.adcdata = v; bus.adcch = rc; acq_n++;
                        if (rc != cfg_ch) begin msum = 0; mcnt = 0; end
                        else begin
                            msum += int'(v); mcnt++;
                            if (mcnt == 4) begin
                                exp_res[cfg_ch] = 12'(msum / 4);
                                exp_valid[cfg_ch] = 1'b1;
                                msum = 0; mcnt = 0;
                            end
                        end
                    end
                    bus.davadc = bus.adcdav;
                end
            end
        end
    end

    task automatic idle_wait();
        int c = 0;
        @(negedge clk);
        while (busy && c < 20000) begin @(negedge clk); c++; end
        chk("idle_wait", busy, 0);
    endtask

    task automatic scan(int passes);
        int c = 0;
        int tgt = sd_cnt + passes;
        run = 1;
        while (sd_cnt < tgt && c < 20000) begin @(negedge clk); c++; end
        chk("scan_done_wait", 32'(sd_cnt >= tgt), 1);
        run = 0;
        idle_wait();
    endtask

    task automatic check_results(string tag);
        for (int k = 0; k < 4; k++) begin
            rdsel = 2'(k);
            @(negedge clk); @(negedge clk);
            chk($sformatf("%s_rd%0d", tag, k), rddata, exp_res[k]);
        end
        chk({tag, "_valid"}, valid, exp_valid);
    endtask

    task automatic chk_order(string tag, logic [3:0] m);
        int en[$];
        for (int k = 0; k < 4; k++) if (m[k]) en.push_back(k);
        chk({tag, "_nconf"}, 32'(conf_q.size() > 0), 1);
        for (int i = 0; i < conf_q.size(); i++)
            chk($sformatf("%s_conf%0d", tag, i), conf_q[i], {4'(1 << en[i % en.size()]), 4'h0});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, cf0;
        rst = 1; run = 0; chmask = 0; rdsel = 0; errclr = 0;
        hold_cf = 0; mute = 0; bad_on = 0; rnd_data = 0;
        for (int k = 0; k < 4; k++) begin chval[k] = 0; exp_res[k] = 0; end
        repeat (3) @(negedge clk);
        chk("rst_adccf", bus.adccf, 0);
        chk("rst_adcdav", bus.adcdav, 0);
        chk("rst_adcconf", bus.adcconf, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_rddata", rddata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", {err, errcode}, 0);
        chk("rst_scan_done", scan_done, 0);
        rst = 0;

        // two channels with fixed values
        chval[0] = 12'd1234; chval[2] = 12'd4095; chmask = 4'b0101; conf_q.delete();
        scan(1);
        chk("s1_conf0", conf_q[0], 8'h10);
        chk("s1_conf1", conf_q[1], 8'h40);
        check_results("s1");
        chk("s1_err", err, 0);

        // one configure, four acquisitions averaged
        chmask = 4'b0010; data_q = '{12'd100, 12'd101, 12'd102, 12'd103};
        conf_q.delete(); cf0 = acq_n; run = 1; c = 0;
        while (conf_q.size() == 0 && c < 1000) begin @(negedge clk); c++; end
        run = 0;
        idle_wait();
        chk("s2_nconf", conf_q.size(), 1);
        chk("s2_conf", conf_q[0], 8'h20);
        chk("s2_nacq", acq_n - cf0, 4);
        check_results("s2");
        rdsel = 1; @(negedge clk); @(negedge clk);
        chk("s2_avg", rddata, 12'd101);

        // acquire never acknowledged
        chmask = 4'b0001; mute = 1; run = 1; c = 0;
        while (!err && c < 6000) begin @(negedge clk); c++; end
        chk("s3_adcdav", bus.adcdav, 0);
        chk("s3_err", {err, errcode}, 3'b101);
        chk("s3_busy", busy, 0);
        mute = 0; errclr = 1;
        @(negedge clk);
        errclr = 0;
        chk("s3_errclr", {err, errcode}, 0);
        chk("s3_tmo_len", 32'(dav_max >= 4094 && dav_max <= 4097), 1);
        scan(1);
        check_results("s3");

        // channel id mismatch on ch1
        chmask = 4'b0110; bad_on = 1; conf_q.delete();
        scan(1);
        chk("s4_conf0", conf_q[0], 8'h20);
        chk("s4_conf1", conf_q[1], 8'h40);
        chk("s4_err", {err, errcode}, 3'b110);
        check_results("s4");
        bad_on = 0; errclr = 1;
        @(negedge clk);
        errclr = 0;

        // run dropped mid-acquire, then IDLE must not start while cfadc is held
        chmask = 4'b0100; rnd_data = 1; run = 1; c = 0;
        while (!bus.adcdav && c < 1000) begin @(negedge clk); c++; end
        chk("s5_acq_seen", bus.adcdav, 1);
        run = 0;
        idle_wait();
        check_results("s5");
        hold_cf = 1;
        repeat (3) @(negedge clk);
        cf0 = cf_cyc; run = 1;
        repeat (40) @(negedge clk);
        chk("s5_no_adccf", cf_cyc - cf0, 0);
        chk("s5_busy", busy, 0);
        run = 0; hold_cf = 0;
        repeat (8) @(negedge clk);

        // randomized scans
        for (int r = 0; r < 6; r++) begin
            chmask = 4'($urandom_range(1, 15)); conf_q.delete();
            scan(2);
            chk_order($sformatf("r%0d", r), chmask);
            check_results($sformatf("r%0d", r));
            chk($sformatf("r%0d_err", r), err, 0);
        end

        // asynchronous reset mid-configure
        chmask = 4'hF; run = 1; c = 0;
        while (!bus.adccf && c < 1000) begin @(negedge clk); c++; end
        rst = 1; #1;
        chk("s6_adccf", bus.adccf, 0);
        chk("s6_valid", valid, 0);
        chk("s6_rddata", rddata, 0);
        chk("s6_busy", busy, 0);
        run = 0; exp_valid = 0;
        for (int k = 0; k < 4; k++) exp_res[k] = 0;
        @(negedge clk);
        rst = 0;
        repeat (4) @(negedge clk);
        check_results("s6");

        chk("req_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
